// File: rtl/axi_pkg.sv
// rtl/axi_pkg.sv - shared AXI burst/response types and burst legality helper
package axi_pkg;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'd0,
        BURST_INCR  = 2'd1,
        BURST_WRAP  = 2'd2,
        BURST_RSVD  = 2'd3
    } burst_t;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'd0,
        RESP_EXOKAY = 2'd1,
        RESP_SLVERR = 2'd2,
        RESP_DECERR = 2'd3
    } resp_t;

    typedef logic [2:0] size_t;

    // WRAP bursts are only legal for 2, 4, 8 or 16 beats.
    function automatic logic wrap_len_ok(input logic [31:0] len);
        return (len == 32'd1) || (len == 32'd3) || (len == 32'd7) || (len == 32'd15);
    endfunction

endpackage

// File: rtl/axi_burst_addr_gen.sv
// rtl/axi_burst_addr_gen.sv - next-beat address and burst legality/range check
module axi_burst_addr_gen
    import axi_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MEM_DEPTH  = 256,
    parameter int LEN_WIDTH  = 8
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [LEN_WIDTH-1:0]  len,
    input  size_t                 size,
    input  logic [1:0]            burst,
    output logic [ADDR_WIDTH-1:0] next_addr,
    output logic                  err
);

    localparam int EW = ADDR_WIDTH + LEN_WIDTH + 8;
    localparam size_t MAX_SIZE = size_t'($clog2(DATA_WIDTH / 8));
    localparam logic [EW-1:0] MEM_BYTES = EW'(MEM_DEPTH * (DATA_WIDTH / 8));

    logic [EW-1:0] a_ext;
    logic [EW-1:0] step;
    logic [EW-1:0] span;
    logic [EW-1:0] mask;
    logic [EW-1:0] hi;
    logic          cfg_err;

    // err treats addr as the first beat: hi is the highest beat address the burst will touch.
    always_comb begin
        a_ext   = EW'(addr);
        step    = EW'(1) << size;
        span    = EW'(len) << size;
        mask    = ((EW'(len) + EW'(1)) << size) - EW'(1);
        cfg_err = (burst == BURST_RSVD) || (size > MAX_SIZE) ||
                  ((burst == BURST_WRAP) && !wrap_len_ok(32'(len)));
        next_addr = addr;
        hi        = a_ext;
        case (burst)
            BURST_INCR: begin
                next_addr = addr + ADDR_WIDTH'(step);
                hi        = a_ext + span;
            end
            BURST_WRAP: begin
                next_addr = ADDR_WIDTH'((a_ext & ~mask) | ((a_ext + step) & mask));
                hi        = (a_ext & ~mask) | mask;
            end
            default: ;
        endcase
        err = cfg_err || (hi >= MEM_BYTES);
    end

endmodule

// File: rtl/axi_mem_slave.sv
// rtl/axi_mem_slave.sv - AXI4 memory slave with independent read and write engines
module axi_mem_slave
    import axi_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MEM_DEPTH  = 256,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                    aclk,
    input  logic                    areset_n,
    input  logic [ADDR_WIDTH-1:0]   awaddr,
    input  logic [LEN_WIDTH-1:0]    awlen,
    input  logic [2:0]              awsize,
    input  logic [1:0]              awburst,
    input  logic                    awvalid,
    output logic                    awready,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic                    wlast,
    input  logic                    wvalid,
    output logic                    wready,
    output logic [1:0]              bresp,
    output logic                    bvalid,
    input  logic                    bready,
    input  logic [ADDR_WIDTH-1:0]   araddr,
    input  logic [LEN_WIDTH-1:0]    arlen,
    input  logic [2:0]              arsize,
    input  logic [1:0]              arburst,
    input  logic                    arvalid,
    output logic                    arready,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic [1:0]              rresp,
    output logic                    rlast,
    output logic                    rvalid,
    input  logic                    rready
);

    localparam int LSB    = $clog2(DATA_WIDTH / 8);
    localparam int IDX_W  = $clog2(MEM_DEPTH);
    localparam int STRB_W = DATA_WIDTH / 8;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    w_state_t w_state, w_state_next;
    r_state_t r_state, r_state_next;
    logic     live;

    logic [ADDR_WIDTH-1:0] w_addr, r_addr;
    logic [LEN_WIDTH-1:0]  w_len, r_len, w_cnt, r_cnt;
    size_t                 w_size, r_size;
    logic [1:0]            w_burst, r_burst;
    logic                  w_err, w_over, r_err;

    logic [ADDR_WIDTH-1:0] wg_addr, wg_next, rg_addr, rg_next;
    logic [LEN_WIDTH-1:0]  wg_len, rg_len;
    size_t                 wg_size, rg_size;
    logic [1:0]            wg_burst, rg_burst;
    logic                  wg_err, rg_err;

    logic aw_hs, w_hs, ar_hs, r_hs, mem_we;
    logic [IDX_W-1:0] w_idx, r_idx, ar_idx;

    assign aw_hs  = awvalid && awready;
    assign w_hs   = wvalid && wready;
    assign ar_hs  = arvalid && arready;
    assign r_hs   = rvalid && rready;
    assign w_idx  = w_addr[LSB +: IDX_W];
    assign r_idx  = r_addr[LSB +: IDX_W];
    assign ar_idx = araddr[LSB +: IDX_W];
    assign mem_we = w_hs && !w_err && !w_over;

    // In idle each generator sees the incoming request so err/next are ready at the handshake.
    assign wg_addr  = (w_state == W_IDLE) ? awaddr  : w_addr;
    assign wg_len   = (w_state == W_IDLE) ? awlen   : w_len;
    assign wg_size  = (w_state == W_IDLE) ? awsize  : w_size;
    assign wg_burst = (w_state == W_IDLE) ? awburst : w_burst;
    assign rg_addr  = (r_state == R_IDLE) ? araddr  : r_addr;
    assign rg_len   = (r_state == R_IDLE) ? arlen   : r_len;
    assign rg_size  = (r_state == R_IDLE) ? arsize  : r_size;
    assign rg_burst = (r_state == R_IDLE) ? arburst : r_burst;

    axi_burst_addr_gen #(
        .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH),
        .MEM_DEPTH(MEM_DEPTH), .LEN_WIDTH(LEN_WIDTH)
    ) u_wgen (
        .addr(wg_addr), .len(wg_len), .size(wg_size), .burst(wg_burst),
        .next_addr(wg_next), .err(wg_err)
    );

    axi_burst_addr_gen #(
        .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH),
        .MEM_DEPTH(MEM_DEPTH), .LEN_WIDTH(LEN_WIDTH)
    ) u_rgen (
        .addr(rg_addr), .len(rg_len), .size(rg_size), .burst(rg_burst),
        .next_addr(rg_next), .err(rg_err)
    );

    always_comb begin
        w_state_next = w_state;
        awready      = live && (w_state == W_IDLE);
        wready       = (w_state == W_DATA);
        bvalid       = (w_state == W_RESP);
        case (w_state)
            W_IDLE:  if (aw_hs)          w_state_next = W_DATA;
            W_DATA:  if (w_hs && wlast)  w_state_next = W_RESP;
            W_RESP:  if (bready)         w_state_next = W_IDLE;
            default:                     w_state_next = W_IDLE;
        endcase
    end

    always_comb begin
        r_state_next = r_state;
        arready      = live && (r_state == R_IDLE);
        case (r_state)
            R_IDLE:  if (ar_hs)          r_state_next = R_DATA;
            R_DATA:  if (r_hs && rlast)  r_state_next = R_IDLE;
            default:                     r_state_next = R_IDLE;
        endcase
    end

    // live keeps the address channels closed while reset is held.
    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            live    <= 1'b0;
            w_state <= W_IDLE;
            w_addr  <= '0;
            w_len   <= '0;
            w_size  <= '0;
            w_burst <= '0;
            w_cnt   <= '0;
            w_err   <= 1'b0;
            w_over  <= 1'b0;
            bresp   <= RESP_OKAY;
        end else begin
            live    <= 1'b1;
            w_state <= w_state_next;
            if (aw_hs) begin
                w_addr  <= awaddr;
                w_len   <= awlen;
                w_size  <= awsize;
                w_burst <= awburst;
                w_err   <= wg_err;
                w_cnt   <= '0;
                w_over  <= 1'b0;
            end
            if (w_hs) begin
                if (!w_over) begin
                    w_addr <= wg_next;
                    if (w_cnt == w_len) w_over <= 1'b1;
                    else                w_cnt  <= w_cnt + 1'b1;
                end
                if (wlast)
                    bresp <= (w_err || w_over || (w_cnt != w_len)) ? RESP_SLVERR : RESP_OKAY;
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (mem_we) begin
            for (int i = 0; i < STRB_W; i++) begin
                if (wstrb[i]) mem[w_idx][i*8 +: 8] <= wdata[i*8 +: 8];
            end
        end
    end

    // Reads sample mem at the same edge as the write port, so a colliding write is seen next time.
    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            r_state <= R_IDLE;
            r_addr  <= '0;
            r_len   <= '0;
            r_size  <= '0;
            r_burst <= '0;
            r_cnt   <= '0;
            r_err   <= 1'b0;
            rvalid  <= 1'b0;
            rlast   <= 1'b0;
            rdata   <= '0;
            rresp   <= RESP_OKAY;
        end else begin
            r_state <= r_state_next;
            if (ar_hs) begin
                r_addr  <= rg_next;
                r_len   <= arlen;
                r_size  <= arsize;
                r_burst <= arburst;
                r_err   <= rg_err;
                r_cnt   <= '0;
                rvalid  <= 1'b1;
                rlast   <= (arlen == '0);
                rresp   <= rg_err ? RESP_SLVERR : RESP_OKAY;
                rdata   <= rg_err ? '0 : mem[ar_idx];
            end else if (r_hs) begin
                if (rlast) begin
                    rvalid <= 1'b0;
                    rlast  <= 1'b0;
                    rdata  <= '0;
                    rresp  <= RESP_OKAY;
                end else begin
                    r_addr <= rg_next;
                    r_cnt  <= r_cnt + 1'b1;
                    rlast  <= (LEN_WIDTH'(r_cnt + 1'b1) == r_len);
                    rdata  <= r_err ? '0 : mem[r_idx];
                end
            end
        end
    end

endmodule

// File: tb/tb_axi_mem_slave.sv
// tb/tb_axi_mem_slave.sv - directed self-checking bench for axi_mem_slave
module tb_axi_mem_slave;

    logic        aclk = 1'b0;
    logic        areset_n;
    logic [31:0] awaddr, araddr, wdata, rdata;
    logic [7:0]  awlen, arlen;
    logic [2:0]  awsize, arsize;
    logic [1:0]  awburst, arburst, bresp, rresp;
    logic [3:0]  wstrb;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rlast, rvalid, rready;

    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] wd   [16];
    logic [31:0] rd_d [16];
    logic [1:0]  rd_r [16];
    logic        rd_l [16];
    logic [1:0]  b_resp;

    axi_mem_slave dut (
        .aclk(aclk), .areset_n(areset_n),
        .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
    );

    always #5 aclk = ~aclk;

    initial begin
        #500000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic timeout(input string tag);
        vectors++;
        miscompares++;
        $error("FAIL %s: handshake timed out, observed none expected one within 50 cycles", tag);
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                            input logic [1:0] burst, input int nbeats, input logic [3:0] strb, input bit bp);
        int t;
        @(negedge aclk);
        awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
        t = 0;
        while (!awready) begin
            @(negedge aclk);
            if (++t > 50) begin timeout("aw"); awvalid = 1'b0; return; end
        end
        @(negedge aclk);
        awvalid = 1'b0;
        for (int b = 0; b < nbeats; b++) begin
            if (bp && $urandom_range(0, 1) == 1) begin wvalid = 1'b0; @(negedge aclk); end
            wdata = wd[b]; wstrb = strb; wlast = (b == nbeats - 1); wvalid = 1'b1;
            t = 0;
            while (!wready) begin
                @(negedge aclk);
                if (++t > 50) begin timeout("w"); wvalid = 1'b0; return; end
            end
            @(negedge aclk);
        end
        wvalid = 1'b0; wlast = 1'b0;
        bready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
        t = 0;
        while (!(bvalid && bready)) begin
            @(negedge aclk);
            bready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            if (++t > 50) begin timeout("b"); bready = 1'b0; return; end
        end
        b_resp = bresp;
        @(negedge aclk);
        bready = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                           input logic [1:0] burst, input bit bp);
        int t;
        @(negedge aclk);
        araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
        t = 0;
        while (!arready) begin
            @(negedge aclk);
            if (++t > 50) begin timeout("ar"); arvalid = 1'b0; return; end
        end
        @(negedge aclk);
        arvalid = 1'b0;
        for (int b = 0; b <= int'(len); b++) begin
            rready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            t = 0;
            while (!(rvalid && rready)) begin
                @(negedge aclk);
                rready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
                if (++t > 50) begin timeout("r"); rready = 1'b0; return; end
            end
            rd_d[b] = rdata; rd_r[b] = rresp; rd_l[b] = rlast;
            @(negedge aclk);
        end
        rready = 1'b0;
    endtask

    initial begin
        areset_n = 1'b0;
        awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
        araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0; rready = 1'b0;
        repeat (3) @(negedge aclk);
        check("reset_outs", {awready, wready, bvalid, arready, rvalid, rlast, bresp, rresp, rdata}, 64'd0);
        areset_n = 1'b1;
        #1 check("ready_before_edge", {awready, arready}, 64'd0);
        @(negedge aclk);
        check("ready_after_edge", {awready, arready}, 64'h3);

        // INCR write then read back
        for (int i = 0; i < 4; i++) wd[i] = 32'hA0 + i;
        do_write(32'h10, 8'd3, 3'd2, 2'd1, 4, 4'hF, 1'b0);
        check("incr_bresp", b_resp, 64'd0);
        do_read(32'h10, 8'd3, 3'd2, 2'd1, 1'b0);
        check("incr_data", {rd_d[0], rd_d[1]}, {32'hA0, 32'hA1});
        check("incr_data2", {rd_d[2], rd_d[3]}, {32'hA2, 32'hA3});
        check("incr_rlast", {rd_l[3], rd_l[2], rd_l[1], rd_l[0]}, 64'b1000);
        check("incr_rresp", {rd_r[0], rd_r[1], rd_r[2], rd_r[3]}, 64'd0);

        do_read(32'h18, 8'd3, 3'd2, 2'd2, 1'b0);
        check("wrap_data", {rd_d[0], rd_d[1]}, {32'hA2, 32'hA3});
        check("wrap_data2", {rd_d[2], rd_d[3]}, {32'hA0, 32'hA1});
        check("wrap_rlast", {rd_l[3], rd_l[2], rd_l[1], rd_l[0]}, 64'b1000);

        do_read(32'h14, 8'd1, 3'd2, 2'd0, 1'b0);
        check("fixed_data", {rd_d[0], rd_d[1]}, {32'hA1, 32'hA1});

        do_read(32'h10, 8'd0, 3'd2, 2'd1, 1'b0);
        check("len0_single", {rd_d[0], 30'd0, rd_r[0], rd_l[0]}, {32'hA0, 30'd0, 2'd0, 1'b1});

        // Partial strobes
        wd[0] = 32'h11223344;
        do_write(32'h40, 8'd0, 3'd2, 2'd1, 1, 4'hF, 1'b0);
        wd[0] = 32'hDEADBEEF;
        do_write(32'h40, 8'd0, 3'd2, 2'd1, 1, 4'h3, 1'b0);
        check("strb_bresp", b_resp, 64'd0);
        do_read(32'h40, 8'd0, 3'd2, 2'd1, 1'b0);
        check("strb_data", rd_d[0], 64'h1122BEEF);

        // Out-of-range accesses alias onto word 0 and must neither read nor write it
        wd[0] = 32'h0BADF00D;
        do_write(32'h0, 8'd0, 3'd2, 2'd1, 1, 4'hF, 1'b0);
        wd[0] = 32'h55555555;
        do_write(32'h400, 8'd0, 3'd2, 2'd1, 1, 4'hF, 1'b0);
        check("oob_bresp", b_resp, 64'd2);
        do_read(32'h400, 8'd1, 3'd2, 2'd1, 1'b0);
        check("oob_rresp", {rd_r[0], rd_r[1]}, 64'hA);
        check("oob_rdata", {rd_d[0], rd_d[1]}, 64'd0);
        check("oob_rlast", {rd_l[1], rd_l[0]}, 64'b10);
        do_read(32'h0, 8'd0, 3'd2, 2'd1, 1'b0);
        check("oob_mem_kept", rd_d[0], 64'h0BADF00D);
        do_read(32'h3FC, 8'd1, 3'd2, 2'd1, 1'b0);
        check("cross_end_rresp", {rd_r[0], rd_r[1], rd_d[0]}, {2'd2, 2'd2, 32'd0});

        do_read(32'h10, 8'd0, 3'd3, 2'd1, 1'b0);
        check("bad_size", {rd_r[0], rd_d[0]}, {2'd2, 32'd0});
        do_read(32'h10, 8'd0, 3'd2, 2'd3, 1'b0);
        check("bad_burst", {rd_r[0], rd_d[0]}, {2'd2, 32'd0});
        do_read(32'h10, 8'd2, 3'd2, 2'd2, 1'b0);
        check("bad_wrap_len", {rd_r[0], rd_r[2], rd_l[2]}, {2'd2, 2'd2, 1'b1});

        // Concurrent traffic with backpressure on disjoint regions
        for (int i = 0; i < 8; i++) wd[i] = 32'hB0000000 + i;
        do_write(32'h200, 8'd7, 3'd2, 2'd1, 8, 4'hF, 1'b0);
        for (int i = 0; i < 8; i++) wd[i] = 32'hC0DE0000 + i;
        fork
            do_write(32'h100, 8'd7, 3'd2, 2'd1, 8, 4'hF, 1'b1);
            do_read(32'h200, 8'd7, 3'd2, 2'd1, 1'b1);
        join
        check("conc_bresp", b_resp, 64'd0);
        for (int i = 0; i < 8; i++) check($sformatf("conc_rd%0d", i), {rd_d[i], 31'd0, rd_l[i]}, {32'hB0000000 + i, 31'd0, (i == 7)});
        do_read(32'h100, 8'd7, 3'd2, 2'd1, 1'b0);
        for (int i = 0; i < 8; i++) check($sformatf("conc_wr%0d", i), rd_d[i], 64'(32'hC0DE0000 + i));

        // wlast early and late
        wd[0] = 32'h77777777; wd[1] = 32'h78787878;
        do_write(32'h80, 8'd3, 3'd2, 2'd1, 2, 4'hF, 1'b0);
        check("early_wlast_bresp", b_resp, 64'd2);
        check("early_wlast_idle", {awready, wready, bvalid}, 64'b100);
        wd[0] = 32'h94949494;
        do_write(32'h94, 8'd0, 3'd2, 2'd1, 1, 4'hF, 1'b0);
        wd[0] = 32'h90909090; wd[1] = 32'h91919191;
        do_write(32'h90, 8'd0, 3'd2, 2'd1, 2, 4'hF, 1'b0);
        check("late_wlast_bresp", b_resp, 64'd2);
        do_read(32'h90, 8'd1, 3'd2, 2'd1, 1'b0);
        check("late_wlast_discard", {rd_d[0], rd_d[1]}, {32'h90909090, 32'h94949494});

        // Reset in the middle of a stalled read
        @(negedge aclk);
        araddr = 32'h200; arlen = 8'd7; arsize = 3'd2; arburst = 2'd1; arvalid = 1'b1;
        @(negedge aclk);
        arvalid = 1'b0;
        check("mid_rvalid", {rvalid, rdata}, {1'b1, 32'hB0000000});
        repeat (2) @(negedge aclk);
        areset_n = 1'b0;
        #1 check("mid_reset_outs", {awready, wready, bvalid, arready, rvalid, rlast, bresp, rresp, rdata}, 64'd0);
        @(negedge aclk);
        areset_n = 1'b1;
        do_read(32'h10, 8'd0, 3'd2, 2'd1, 1'b0);
        check("after_reset_read", {rd_d[0], 29'd0, rd_r[0], rd_l[0]}, {32'hA0, 29'd0, 2'd0, 1'b1});

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
